// File: rtl/sal_pkg.sv
// Shared types and default timing constants for the per-bank DDR2 command gate.
//   cmd_e        : scheduler / command-bus opcode (ACT, RD, WR, PRE)
//   bank_state_e : bank closed (S_IDLE) or row open (S_ACTIVE)
//   DEF_*        : default widths and DDR2 timing values in clock cycles
package sal_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } bank_state_e;

  localparam int unsigned DEF_ROW_WIDTH  = 14;
  localparam int unsigned DEF_CNTR_WIDTH = 4;
  localparam int unsigned DEF_T_RCD      = 3;
  localparam int unsigned DEF_T_RAS      = 8;
  localparam int unsigned DEF_T_RTP      = 2;
  localparam int unsigned DEF_T_WR       = 7;
  localparam int unsigned DEF_T_RP       = 3;

endpackage

// File: rtl/sal_timing_cntr.sv
// Saturating down-counter for one DRAM timing constraint.
//   clk, rst        : clock, synchronous active-high reset
//   reset_cmd_i     : load reset_value_i this cycle
//   reset_value_i   : value loaded (T - 1)
//   is_zero_o       : registered flag, high while the counter sits at zero
module sal_timing_cntr
  import sal_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = DEF_CNTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_cmd_i,
  input  logic [CNTR_WIDTH-1:0] reset_value_i,
  output logic                  is_zero_o
);

  logic [CNTR_WIDTH-1:0] cnt_q;
  logic [CNTR_WIDTH-1:0] cnt_d;

  // Load wins over decrement; saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (reset_cmd_i) begin
      cnt_d = reset_value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNTR_WIDTH'(1);
    end
  end

  // Zero flag is registered from the next value so readiness has no counter compare in its path.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      is_zero_o <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      is_zero_o <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/sal_bank_timing_ctrl.sv
// Per-bank DDR2 command gate between scheduler and command-bus mux.
// Tracks open/closed state and open row, and accepts a legal command only once
// tRCD / tRAS / tRTP / tWR / tRP have elapsed. Illegal commands are accepted,
// dropped and flagged on err_o.
//   clk, rst                           : clock, synchronous active-high reset
//   req_valid_i, req_cmd_i, req_row_i  : scheduler request
//   req_ready_o                        : combinational accept (no path from req_valid_i)
//   cmd_valid_o, cmd_o, cmd_row_o      : registered issued-command strobe and payload
//   bank_open_o, open_row_o            : registered bank state
//   err_o                              : registered one-cycle illegal-command pulse
module sal_bank_timing_ctrl
  import sal_pkg::*;
#(
  parameter int unsigned ROW_WIDTH  = DEF_ROW_WIDTH,
  parameter int unsigned CNTR_WIDTH = DEF_CNTR_WIDTH,
  parameter int unsigned T_RCD      = DEF_T_RCD,
  parameter int unsigned T_RAS      = DEF_T_RAS,
  parameter int unsigned T_RTP      = DEF_T_RTP,
  parameter int unsigned T_WR       = DEF_T_WR,
  parameter int unsigned T_RP       = DEF_T_RP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_i,
  input  logic [1:0]           req_cmd_i,
  input  logic [ROW_WIDTH-1:0] req_row_i,
  output logic                 req_ready_o,
  output logic                 cmd_valid_o,
  output logic [1:0]           cmd_o,
  output logic [ROW_WIDTH-1:0] cmd_row_o,
  output logic                 bank_open_o,
  output logic [ROW_WIDTH-1:0] open_row_o,
  output logic                 err_o
);

  cmd_e        req_cmd;
  bank_state_e state_q;
  bank_state_e state_d;

  logic legal_c;
  logic accept_c;
  logic issue_c;
  logic ld_rcd_ras_c;
  logic ld_rtp_c;
  logic ld_wr_c;
  logic ld_rp_c;

  logic rcd_zero;
  logic ras_zero;
  logic rtp_zero;
  logic wr_zero;
  logic rp_zero;

  logic                 cmd_valid_q;
  cmd_e                 cmd_q;
  logic [ROW_WIDTH-1:0] cmd_row_q;
  logic                 bank_open_q;
  logic [ROW_WIDTH-1:0] open_row_q;
  logic                 err_q;

  assign req_cmd = cmd_e'(req_cmd_i);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: only an issued ACT opens and an issued PRE closes the bank.
  always_comb begin
    state_d = state_q;
    if (issue_c) begin
      case (req_cmd)
        CMD_ACT: state_d = S_ACTIVE;
        CMD_PRE: state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Legality, readiness and counter-load decode.
  always_comb begin
    legal_c      = 1'b0;
    req_ready_o  = 1'b1;
    ld_rcd_ras_c = 1'b0;
    ld_rtp_c     = 1'b0;
    ld_wr_c      = 1'b0;
    ld_rp_c      = 1'b0;

    if (state_q == S_IDLE) begin
      legal_c = (req_cmd == CMD_ACT);
    end else begin
      legal_c = (req_cmd != CMD_ACT);
    end

    // Illegal commands are always ready so they drain immediately.
    if (legal_c) begin
      case (req_cmd)
        CMD_ACT: req_ready_o = rp_zero;
        CMD_RD,
        CMD_WR:  req_ready_o = rcd_zero;
        CMD_PRE: req_ready_o = ras_zero & rtp_zero & wr_zero;
        default: req_ready_o = 1'b1;
      endcase
    end

    accept_c = req_valid_i & req_ready_o;
    issue_c  = accept_c & legal_c;

    if (issue_c) begin
      case (req_cmd)
        CMD_ACT: ld_rcd_ras_c = 1'b1;
        CMD_RD:  ld_rtp_c     = 1'b1;
        CMD_WR:  ld_wr_c      = 1'b1;
        CMD_PRE: ld_rp_c      = 1'b1;
        default: ;
      endcase
    end
  end

  // Issued-command strobe, error pulse and bank-state output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_ACT;
      cmd_row_q   <= '0;
      bank_open_q <= 1'b0;
      open_row_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= issue_c;
      err_q       <= accept_c & ~legal_c;
      bank_open_q <= (state_d == S_ACTIVE);
      if (issue_c) begin
        cmd_q     <= req_cmd;
        cmd_row_q <= (req_cmd == CMD_ACT) ? req_row_i : open_row_q;
        if (req_cmd == CMD_ACT) begin
          open_row_q <= req_row_i;
        end
      end
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_row_o   = cmd_row_q;
  assign bank_open_o = bank_open_q;
  assign open_row_o  = open_row_q;
  assign err_o       = err_q;

  // One saturating counter per constraint; tRCD and tRAS share the ACT load.
  sal_timing_cntr #(.CNTR_WIDTH(CNTR_WIDTH)) u_rcd (
    .clk(clk), .rst(rst), .reset_cmd_i(ld_rcd_ras_c),
    .reset_value_i(CNTR_WIDTH'(T_RCD - 1)), .is_zero_o(rcd_zero)
  );

  sal_timing_cntr #(.CNTR_WIDTH(CNTR_WIDTH)) u_ras (
    .clk(clk), .rst(rst), .reset_cmd_i(ld_rcd_ras_c),
    .reset_value_i(CNTR_WIDTH'(T_RAS - 1)), .is_zero_o(ras_zero)
  );

  sal_timing_cntr #(.CNTR_WIDTH(CNTR_WIDTH)) u_rtp (
    .clk(clk), .rst(rst), .reset_cmd_i(ld_rtp_c),
    .reset_value_i(CNTR_WIDTH'(T_RTP - 1)), .is_zero_o(rtp_zero)
  );

  sal_timing_cntr #(.CNTR_WIDTH(CNTR_WIDTH)) u_wr (
    .clk(clk), .rst(rst), .reset_cmd_i(ld_wr_c),
    .reset_value_i(CNTR_WIDTH'(T_WR - 1)), .is_zero_o(wr_zero)
  );

  sal_timing_cntr #(.CNTR_WIDTH(CNTR_WIDTH)) u_rp (
    .clk(clk), .rst(rst), .reset_cmd_i(ld_rp_c),
    .reset_value_i(CNTR_WIDTH'(T_RP - 1)), .is_zero_o(rp_zero)
  );

endmodule

// File: tb/tb_sal_bank_timing_ctrl.sv
// Bench for sal_bank_timing_ctrl: cycle-stamp reference model checked every
// cycle, plus directed scenarios with hand-computed accept latencies.
module tb_sal_bank_timing_ctrl;

  localparam int unsigned ROW_W = 14;
  localparam int T_RCD = 3;
  localparam int T_RAS = 8;
  localparam int T_RTP = 2;
  localparam int T_WR  = 7;
  localparam int T_RP  = 3;

  localparam logic [1:0] ACT = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] WR  = 2'd2;
  localparam logic [1:0] PRE = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [1:0]       req_cmd = 2'd0;
  logic [ROW_W-1:0] req_row = '0;
  logic             req_ready_o;
  logic             cmd_valid_o;
  logic [1:0]       cmd_o;
  logic [ROW_W-1:0] cmd_row_o;
  logic             bank_open_o;
  logic [ROW_W-1:0] open_row_o;
  logic             err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sal_bank_timing_ctrl #(
    .ROW_WIDTH(ROW_W), .CNTR_WIDTH(4),
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RTP(T_RTP), .T_WR(T_WR), .T_RP(T_RP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_cmd_i(req_cmd), .req_row_i(req_row),
    .req_ready_o(req_ready_o),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_row_o(cmd_row_o),
    .bank_open_o(bank_open_o), .open_row_o(open_row_o), .err_o(err_o)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each constraint is the absolute cycle at which it expires.
  int               cyc = 0;
  bit               chk_en = 1'b0;
  bit               m_open = 1'b0;
  logic [ROW_W-1:0] m_row = '0;
  int               rcd_at = 0, ras_at = 0, rtp_at = 0, wr_at = 0, rp_at = 0;
  bit               e_cv = 1'b0, e_err = 1'b0;
  logic [1:0]       e_cmd = 2'd0;
  logic [ROW_W-1:0] e_row = '0;

  function automatic bit m_legal(input logic [1:0] c);
    return m_open ? (c != ACT) : (c == ACT);
  endfunction

  function automatic bit m_ready(input logic [1:0] c);
    if (!m_legal(c)) return 1'b1;
    case (c)
      ACT:     return cyc >= rp_at;
      RD, WR:  return cyc >= rcd_at;
      default: return (cyc >= ras_at) && (cyc >= rtp_at) && (cyc >= wr_at);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      chk_en = 1'b1;
      m_open = 1'b0;
      m_row  = '0;
      rcd_at = 0; ras_at = 0; rtp_at = 0; wr_at = 0; rp_at = 0;
      e_cv   = 1'b0;
      e_err  = 1'b0;
    end else begin
      e_cv  = 1'b0;
      e_err = 1'b0;
      if (req_valid && m_ready(req_cmd)) begin
        if (m_legal(req_cmd)) begin
          e_cv  = 1'b1;
          e_cmd = req_cmd;
          e_row = (req_cmd == ACT) ? req_row : m_row;
          case (req_cmd)
            ACT: begin
              m_open = 1'b1;
              m_row  = req_row;
              rcd_at = cyc + T_RCD;
              ras_at = cyc + T_RAS;
            end
            RD:      rtp_at = cyc + T_RTP;
            WR:      wr_at  = cyc + T_WR;
            default: begin
              m_open = 1'b0;
              rp_at  = cyc + T_RP;
            end
          endcase
        end else begin
          e_err = 1'b1;
        end
      end
    end
    cyc++;
  end

  // Per-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cmd_valid", 32'(cmd_valid_o), 32'(e_cv));
      cmp("err", 32'(err_o), 32'(e_err));
      cmp("bank_open", 32'(bank_open_o), 32'(m_open));
      cmp("open_row", 32'(open_row_o), 32'(m_row));
      cmp("req_ready", 32'(req_ready_o), 32'(m_ready(req_cmd)));
      if (e_cv) begin
        cmp("cmd", 32'(cmd_o), 32'(e_cmd));
        cmp("cmd_row", 32'(cmd_row_o), 32'(e_row));
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; waited = cycles stalled before the accept cycle.
  task automatic issue(input logic [1:0] c, input logic [ROW_W-1:0] r, output int waited);
    req_valid = 1'b1;
    req_cmd   = c;
    req_row   = r;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o) break;
      waited++;
      if (waited > 20) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: cmd %0d not accepted within 20 cycles", c);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  int n;

  initial begin
    // Reset held 3 cycles.
    req_cmd = ACT;
    do_reset(3);
    cmp("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    cmp("rst_bank_open", 32'(bank_open_o), 32'd0);
    cmp("rst_open_row", 32'(open_row_o), 32'd0);
    cmp("rst_err", 32'(err_o), 32'd0);
    cmp("rst_ready_act", 32'(req_ready_o), 32'd1);

    // ACT then RD.
    issue(ACT, 14'h1A5, n);
    cmp("act_wait", 32'(n), 32'd0);
    cmp("act_issue_cmd", 32'(cmd_o), 32'(ACT));
    cmp("act_issue_row", 32'(cmd_row_o), 32'h1A5);
    cmp("act_bank_open", 32'(bank_open_o), 32'd1);
    issue(RD, 14'h3FFF, n);
    cmp("rd_after_act_wait", 32'(n), 32'd2);
    cmp("rd_issue_cmd", 32'(cmd_o), 32'(RD));
    cmp("rd_issue_row", 32'(cmd_row_o), 32'h1A5);

    // ACT, PRE (tRAS), ACT (tRP).
    do_reset(1);
    issue(ACT, 14'h0042, n);
    issue(PRE, '0, n);
    cmp("pre_tras_wait", 32'(n), 32'd7);
    cmp("pre_bank_closed", 32'(bank_open_o), 32'd0);
    issue(ACT, 14'h0077, n);
    cmp("act_trp_wait", 32'(n), 32'd2);

    // Write recovery dominates tRAS.
    do_reset(1);
    issue(ACT, 14'h0100, n);
    idle(2);
    issue(WR, '0, n);
    cmp("wr_at3_wait", 32'(n), 32'd0);
    issue(PRE, '0, n);
    cmp("pre_twr_wait", 32'(n), 32'd6);

    // RD at 3: tRAS dominates.
    do_reset(1);
    issue(ACT, 14'h0101, n);
    idle(2);
    issue(RD, '0, n);
    issue(PRE, '0, n);
    cmp("pre_rd_tras_wait", 32'(n), 32'd4);

    // Illegal commands.
    do_reset(1);
    issue(RD, '0, n);
    cmp("ill_rd_wait", 32'(n), 32'd0);
    cmp("ill_rd_err", 32'(err_o), 32'd1);
    cmp("ill_rd_cv", 32'(cmd_valid_o), 32'd0);
    cmp("ill_rd_open", 32'(bank_open_o), 32'd0);
    issue(ACT, 14'h0123, n);
    idle(1);
    issue(ACT, 14'h3FF, n);
    cmp("ill_act_wait", 32'(n), 32'd0);
    cmp("ill_act_err", 32'(err_o), 32'd1);
    cmp("ill_act_cv", 32'(cmd_valid_o), 32'd0);
    cmp("ill_act_row", 32'(open_row_o), 32'h0123);

    // Mid-operation reset.
    do_reset(1);
    issue(ACT, 14'h0055, n);
    idle(1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("midrst_open", 32'(bank_open_o), 32'd0);
    cmp("midrst_row", 32'(open_row_o), 32'd0);
    rst = 1'b0;
    issue(ACT, 14'h0066, n);
    cmp("midrst_act_wait", 32'(n), 32'd0);
    cmp("midrst_act_open", 32'(bank_open_o), 32'd1);

    // Mixed traffic, checked by the per-cycle model.
    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_cmd   = 2'($urandom_range(0, 3));
      req_row   = ROW_W'($urandom);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sal_bank_timing_ctrl.md
# sal_bank_timing_ctrl

Per-bank DDR2 command gate: accepts ACT/RD/WR/PRE requests from the scheduler, tracks bank open/closed state and the open row, and only accepts a legal command once every applicable DRAM timing constraint (tRCD, tRAS, tRTP, tWR, tRP) has elapsed. It loads and polls a set of saturating timing counters. It sits between the scheduler and the command-bus mux, one instance per bank.

## Interface
- ROW_WIDTH, 14, row address width
- CNTR_WIDTH, 4, timing-counter width; must hold max(t*) - 1
- T_RCD, 3, ACT to RD/WR, cycles
- T_RAS, 8, ACT to PRE, cycles
- T_RTP, 2, RD to PRE, cycles
- T_WR, 7, WR to PRE, cycles; includes WL + BL/2 + tWR
- T_RP, 3, PRE to ACT, cycles
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_cmd_i  in  2  0 = ACT, 1 = RD, 2 = WR, 3 = PRE
- req_row_i  in  ROW_WIDTH  row for ACT; ignored otherwise
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- cmd_valid_o  out  1  issued-command strobe, registered
- cmd_o  out  2  issued command
- cmd_row_o  out  ROW_WIDTH  row of issued ACT; open row otherwise
- bank_open_o  out  1  bank in ACTIVE state
- open_row_o  out  ROW_WIDTH  currently open row
- err_o  out  1  one-cycle pulse: illegal command dropped

## Operation
- States: IDLE (bank closed), ACTIVE (row open).
- Legality:
  - ACT is legal in IDLE.
  - RD, WR and PRE are legal in ACTIVE.
  - All others are illegal.
- Readiness:
  - Legal ACT is ready when tRP is zero.
  - Legal RD/WR is ready when tRCD is zero.
  - Legal PRE is ready when tRAS, tRTP and tWR are all zero.
  - An illegal command is always ready.
- Accepting a legal command:
  - ACT: IDLE->ACTIVE, latch open_row; load tRCD = T_RCD-1 and tRAS = T_RAS-1.
  - RD: load tRTP = T_RTP-1.
  - WR: load tWR = T_WR-1.
  - PRE: ACTIVE->IDLE; load tRP = T_RP-1.
- Counter semantics: each counter loads on its command, decrements to 0 and saturates there. "Zero" means the registered is_zero output.
- Repeated RD/WR simply reloads its counter. This is monotone, so no max logic is needed.
- Illegal accepted command: no state or counter change, no issue, err_o pulses.
- Every T_* must be ≥ 1. T_*=1 loads 0, so the next command is allowed on the following cycle.

## Timing
- req_ready_o is combinational from registered state and counter zero flags only; it has no path from req_valid_i.
- Command accepted in cycle k:
  - cmd_valid_o, cmd_o and cmd_row_o are asserted in cycle k+1, for exactly 1 cycle.
  - State, bank_open_o and open_row_o update in cycle k+1.
  - err_o (illegal only) pulses in cycle k+1.
- Constraint of T cycles: the dependent command is first ready in cycle k+T. Back-to-back accepts are allowed every cycle.
- PRE readiness is max over the tRAS, tRTP and tWR expiries.
- Reset values: state IDLE, all counters 0, every output 0 (bank_open_o 0, open_row_o 0, cmd_valid_o 0, err_o 0).
- req_ready_o is 1 for ACT on the first cycle after rst deasserts.
- Reset mid-operation clears everything in the next cycle. tRP is not enforced across reset; the system resets the DRAM too.
- req_row_i is ignored for non-ACT commands. cmd_row_o carries open_row for RD/WR/PRE.

## Structure
- SAL_PKG holds:
  - the command typedef enum (CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, 2 bits);
  - the bank state enum (S_IDLE, S_ACTIVE);
  - shared default timing constants.
- Sub-module: five instances of SAL_TIMING_CNTR (CNTR_WIDTH), one each for tRCD, tRAS, tRTP, tWR and tRP.
  - reset_cmd_i is driven by the accept-and-legal decode.
  - reset_value_i is T_*-1.
- The rest is one FSM plus output registers.

## Test plan
- Reset:
  - Hold rst for 3 cycles -> all outputs 0.
  - After release, req_ready_o=1 with req_cmd_i=ACT.
- ACT then RD:
  - ACT row 0x1A5 accepted at cycle 0; RD held valid from cycle 1.
  - Required: req_ready_o rises at cycle 3; cmd_valid_o with ACT/0x1A5 at cycle 1 and RD/0x1A5 at cycle 4.
  - bank_open_o=1 from cycle 1.
- ACT, PRE, ACT:
  - ACT at 0; PRE held from 1 -> PRE accepted at 8.
  - ACT held afterward -> accepted at 11.
  - bank_open_o=0 from cycle 9.
- Write recovery:
  - ACT at 0, WR accepted at 3, PRE held from 4 -> PRE accepted at 10, not 8.
  - RD instead of WR at 3 -> PRE accepted at 8.
- Illegal:
  - RD in IDLE at cycle 0 -> req_ready_o=1, err_o=1 at cycle 1, cmd_valid_o stays 0, bank_open_o stays 0.
  - ACT in ACTIVE -> same response; open_row_o unchanged.
- Mid-op reset:
  - ACT at 0, rst at cycle 2 -> cycle 3 shows bank_open_o=0.
  - ACT accepted on the first cycle after rst deasserts.
